// File: rtl/snake_pkg.sv
// Shared types for the snake display path: object codes, grid size,
// the queued draw entry and the writer FSM encoding.
package snake_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 12;

  typedef enum logic [2:0] {
    OBJ_EMPTY  = 3'b000,
    OBJ_HEAD   = 3'b001,
    OBJ_BODY   = 3'b010,
    OBJ_APPLE  = 3'b011,
    OBJ_BORDER = 3'b100
  } obj_code_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    obj_code_t  code;
  } draw_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } writer_state_t;

  // Zero-extended compares keep the check meaningful for any grid size.
  function automatic logic in_grid(input logic [3:0] cx, input logic [3:0] cy);
    return ({1'b0, cx} < 5'(GRID_W)) && ({1'b0, cy} < 5'(GRID_H));
  endfunction

endpackage

// File: rtl/cell_fifo.sv
// Synchronous FIFO of draw entries with registered occupancy count.
// A write while full is accepted only when a read frees a slot in the same cycle.
module cell_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              push,
  input  logic              pop,
  input  draw_entry_t       wdata,
  output draw_entry_t       rdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  draw_entry_t   mem [DEPTH];
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/diff_draw_queue.sv
// Queues changed grid cells and feeds them one at a time to the display writer
// using a ready handshake followed by a completion pulse.
module diff_draw_queue
  import snake_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       scan_valid,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  input  logic       diff,
  input  logic       draw_ready,
  input  logic       draw_done,
  output logic       draw_valid,
  output logic [3:0] draw_x,
  output logic [3:0] draw_y,
  output logic [2:0] draw_code,
  output logic [4:0] count,
  output logic       overflow,
  output logic       idle,
  output logic [1:0] fsm_state
);

  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a request transfers on a rising edge where draw_valid and
  // draw_ready are both 1; payload is held unchanged while draw_valid waits.
  writer_state_t state;
  writer_state_t state_nx;
  logic          pop;
  logic          push_req;
  logic          drop;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;
  draw_entry_t   wentry;
  draw_entry_t   rentry;
  draw_entry_t   out_q;

  assign push_req    = scan_valid && diff && in_grid(x, y);
  assign wentry.x    = x;
  assign wentry.y    = y;
  assign wentry.code = obj_code_t'(obj_code);

  cell_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push_req),
    .pop   (pop),
    .wdata (wentry),
    .rdata (rentry),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_nx = ST_SEND;
          pop      = 1'b1;
        end
      end
      ST_SEND: begin
        if (draw_ready) state_nx = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (draw_done) begin
          if (!empty) begin
            state_nx = ST_SEND;
            pop      = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A drop only happens when the FIFO cannot make room this cycle.
  assign drop = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      out_q    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop)  out_q    <= rentry;
      if (drop) overflow <= 1'b1;
    end
  end

  assign draw_valid = (state == ST_SEND);
  assign draw_x     = out_q.x;
  assign draw_y     = out_q.y;
  assign draw_code  = out_q.code;
  assign count      = 5'(fifo_count);
  assign idle       = empty && (state == ST_IDLE);
  assign fsm_state  = state;

endmodule

// File: tb/tb_diff_draw_queue.sv
// Directed bench for diff_draw_queue: stimulus pushes expected entries into a
// queue, a monitor thread pops and compares on every accepted request.
module tb_diff_draw_queue;

  logic       clk = 1'b0;
  logic       nrst;
  logic       scan_valid;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       diff;
  logic       draw_ready;
  logic       draw_done;
  logic       draw_valid;
  logic [3:0] draw_x;
  logic [3:0] draw_y;
  logic [2:0] draw_code;
  logic [4:0] count;
  logic       overflow;
  logic       idle;
  logic [1:0] fsm_state;

  logic       auto_done  = 1'b0;
  logic       done_pulse = 1'b0;
  logic       man_done   = 1'b0;
  logic       seen_valid = 1'b0;
  int         checks     = 0;
  int         errors     = 0;
  int         accepts    = 0;
  int         a0;
  logic       ok;
  logic [10:0] exp_q[$];

  assign draw_done = done_pulse | man_done;

  always #5 clk = ~clk;

  diff_draw_queue #(.DEPTH(16)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .scan_valid (scan_valid),
    .x          (x),
    .y          (y),
    .obj_code   (obj_code),
    .diff       (diff),
    .draw_ready (draw_ready),
    .draw_done  (draw_done),
    .draw_valid (draw_valid),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_code  (draw_code),
    .count      (count),
    .overflow   (overflow),
    .idle       (idle),
    .fsm_state  (fsm_state)
  );

  function automatic logic [10:0] ent(input logic [3:0] cx, input logic [3:0] cy,
                                      input logic [2:0] cc);
    return {cx, cy, cc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic scan(input logic [3:0] cx, input logic [3:0] cy, input logic [2:0] cc,
                      input logic cd, input logic expect_push);
    scan_valid = 1'b1;
    x          = cx;
    y          = cy;
    obj_code   = cc;
    diff       = cd;
    if (expect_push) exp_q.push_back(ent(cx, cy, cc));
    @(posedge clk); #1;
    scan_valid = 1'b0;
    diff       = 1'b0;
  endtask

  task automatic reset_dut();
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_idle(input int bound, input string name);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (idle) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    nrst       = 1'b0;
    scan_valid = 1'b0;
    x          = '0;
    y          = '0;
    obj_code   = '0;
    diff       = 1'b0;
    draw_ready = 1'b0;

    fork
      // Scoreboard monitor: compare each accepted request with the queue head.
      forever begin
        @(negedge clk);
        if (draw_valid) seen_valid = 1'b1;
        if (nrst && draw_valid && draw_ready) begin
          accepts++;
          if (exp_q.size() == 0) begin
            check("sb_unexpected", 32'({draw_x, draw_y, draw_code}), 32'h7ff);
          end else begin
            check("sb_entry", 32'({draw_x, draw_y, draw_code}), 32'(exp_q.pop_front()));
          end
        end
      end
      // Writer model: draw_done one cycle after the accepting edge.
      forever begin
        @(negedge clk);
        if (nrst && draw_valid && draw_ready && auto_done) begin
          @(posedge clk);
          @(posedge clk); #1;
          done_pulse = 1'b1;
          @(posedge clk); #1;
          done_pulse = 1'b0;
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(draw_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_payload", 32'({draw_x, draw_y, draw_code}), 32'd0);
    nrst = 1'b1;

    // Full frame with no changes, then changed cells just outside the grid.
    seen_valid = 1'b0;
    for (int i = 0; i < 192; i++) scan(4'(i % 16), 4'(i / 16), 3'(i % 5), 1'b0, 1'b0);
    scan(4'd3, 4'd12, 3'b010, 1'b1, 1'b0);
    scan(4'd0, 4'd15, 3'b001, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("nodiff_seen_valid", 32'(seen_valid), 32'd0);
    check("nodiff_count", 32'(count), 32'd0);
    check("nodiff_idle", 32'(idle), 32'd1);

    // Three changed cells, writer always ready.
    draw_ready = 1'b1;
    auto_done  = 1'b1;
    a0 = accepts;
    scan(4'd4, 4'd4, 3'b010, 1'b1, 1'b1);
    scan(4'd5, 4'd4, 3'b001, 1'b1, 1'b1);
    scan(4'd7, 4'd4, 3'b011, 1'b1, 1'b1);
    wait_idle(60, "three_idle");
    check("three_accepts", 32'(accepts - a0), 32'd3);
    check("three_q_empty", 32'(exp_q.size()), 32'd0);

    // Stall: ready low for 10 cycles after the first draw_valid.
    draw_ready = 1'b0;
    scan(4'd9, 4'd3, 3'b011, 1'b1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (draw_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("stall_valid_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(draw_valid), 32'd1);
      check("stall_payload", 32'({draw_x, draw_y, draw_code}), 32'(ent(4'd9, 4'd3, 3'b011)));
      @(posedge clk); #1;
    end
    a0 = accepts;
    draw_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_accept_c11", 32'(accepts - a0), 32'd1);
    check("stall_wait_done", 32'(draw_valid), 32'd0);
    wait_idle(20, "stall_idle");

    // 18 changed cells with writer stalled: one held, 16 queued, one dropped.
    auto_done  = 1'b0;
    draw_ready = 1'b0;
    reset_dut();
    for (int i = 0; i < 18; i++)
      scan(4'(i % 16), 4'(1 + i / 16), 3'(i % 5), 1'b1, i < 17);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head_valid", 32'(draw_valid), 32'd1);
    check("ovf_head_payload", 32'({draw_x, draw_y, draw_code}), 32'(ent(4'd0, 4'd1, 3'd0)));
    a0 = accepts;
    draw_ready = 1'b1;
    auto_done  = 1'b1;
    wait_idle(200, "ovf_idle");
    check("ovf_accepts", 32'(accepts - a0), 32'd17);
    check("ovf_q_empty", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a push and a pop on the same edge.
    auto_done  = 1'b0;
    draw_ready = 1'b0;
    reset_dut();
    for (int i = 0; i < 17; i++)
      scan(4'(i % 16), 4'(5 + i / 16), 3'((i + 2) % 5), 1'b1, 1'b1);
    check("full_count", 32'(count), 32'd16);
    check("full_overflow", 32'(overflow), 32'd0);
    a0 = accepts;
    draw_ready = 1'b1;
    @(posedge clk); #1;
    draw_ready = 1'b0;
    check("full_wait_done", 32'(draw_valid), 32'd0);
    man_done = 1'b1;
    scan(4'd2, 4'd9, 3'b100, 1'b1, 1'b1);
    man_done = 1'b0;
    check("pushpop_count", 32'(count), 32'd16);
    check("pushpop_overflow", 32'(overflow), 32'd0);
    check("pushpop_send", 32'(draw_valid), 32'd1);
    draw_ready = 1'b1;
    auto_done  = 1'b1;
    wait_idle(200, "pushpop_idle");
    check("pushpop_accepts", 32'(accepts - a0), 32'd18);
    check("pushpop_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset while waiting for draw_done with five entries queued.
    auto_done  = 1'b0;
    draw_ready = 1'b0;
    reset_dut();
    for (int i = 0; i < 6; i++) scan(4'(i), 4'd10, 3'b100, 1'b1, 1'b1);
    draw_ready = 1'b1;
    @(posedge clk); #1;
    draw_ready = 1'b0;
    check("mid_count", 32'(count), 32'd5);
    check("mid_wait_done", 32'(draw_valid), 32'd0);
    nrst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(draw_valid), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd1);
    check("mid_rst_payload", 32'({draw_x, draw_y, draw_code}), 32'd0);
    nrst = 1'b1;
    seen_valid = 1'b0;
    a0 = accepts;
    draw_ready = 1'b1;
    man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("late_done_no_valid", 32'(seen_valid), 32'd0);
    check("late_done_no_accept", 32'(accepts - a0), 32'd0);
    check("late_done_idle", 32'(idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/diff_draw_queue.md
DIFF_DRAW_QUEUE -- requirements
Module: diff_draw_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entry count (power of two, >=2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port scan_valid  input  1  x/y/obj_code/diff valid for the current cell this cycle.
REQ-005 SHALL have port x  input  4  scanned cell column, 0..15.
REQ-006 SHALL have port y  input  4  scanned cell row, 0..11.
REQ-007 SHALL have port obj_code  input  3  cell content (empty/head/body/apple/border).
REQ-008 SHALL have port diff  input  1  cell content changed since the previous frame.
REQ-009 SHALL have port draw_ready  input  1  display writer accepts a request.
REQ-010 SHALL have port draw_done  input  1  one-cycle pulse: display writer finished the accepted cell.
REQ-011 SHALL have port draw_valid  output  1  request pending on draw_x/draw_y/draw_code.
REQ-012 SHALL have port draw_x, draw_y, draw_code  output  4/4/3  cell to redraw.
REQ-013 SHALL have port count  output  5  current FIFO occupancy, 0..DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky: a changed cell was dropped.
REQ-015 SHALL have port idle  output  1  FIFO empty and FSM in IDLE.

Function
REQ-016 Push SHALL occur when scan_valid=1, diff=1, x<=15, y<=11, and (count<DEPTH or a pop happens the same cycle); entry = {x,y,obj_code}.
REQ-017 Cells with diff=0 or scan_valid=0 SHALL never be pushed.
REQ-018 When a push is required but the FIFO is full with no same-cycle pop, the entry SHALL be dropped, overflow set to 1, and the FIFO contents left unchanged.
REQ-019 overflow SHALL stay 1 until reset.
REQ-020 Writer FSM states SHALL be IDLE, SEND, and WAIT_DONE.
REQ-021 IDLE -> SEND on the cycle after count>0; the head entry is popped into output registers on that transition (pop).
REQ-022 SEND SHALL hold draw_valid=1 with stable draw_x/draw_y/draw_code until draw_ready=1; on draw_valid&&draw_ready, SEND -> WAIT_DONE.
REQ-023 WAIT_DONE SHALL hold draw_valid=0; on draw_done=1 it goes to SEND with a pop if count>0, else to IDLE.
REQ-024 draw_done SHALL be ignored outside WAIT_DONE.
REQ-025 Minimum spacing SHALL be one request per 3 cycles with draw_ready tied high and draw_done returned one cycle after acceptance.
REQ-026 A simultaneous push and pop SHALL leave count unchanged; read/write pointers wrap modulo DEPTH.
REQ-027 Entries SHALL be emitted in strict push (scan) order.
REQ-028 idle SHALL be 1 exactly when count=0 and state=IDLE.

Reset
REQ-029 While nrst=0 at a rising edge: FIFO emptied, count=0, state=IDLE, draw_valid=0, draw_x/draw_y/draw_code=0, overflow=0, idle=1.
REQ-030 Reset mid-SEND/WAIT_DONE SHALL abandon the in-flight request without emitting it again.

Structure
REQ-031 Shared package snake_pkg SHALL hold the obj_code typedef (000 empty, 001 head, 010 body, 011 apple, 100 border), GRID_W=16, GRID_H=12, and the draw-entry struct.
REQ-032 The FIFO SHALL be a sub-module cell_fifo (sync, registered count, full/empty flags); the FSM and overflow logic stay in diff_draw_queue.

Verification
REQ-033 Reset then scan 192 cells with diff=0 -> draw_valid never 1, count=0, idle=1.
REQ-034 diff=1 at (4,4) code 010, (5,4) 001, (7,4) 011; draw_ready=1, draw_done one cycle after acceptance -> three requests in that order, then idle=1.
REQ-035 draw_ready=0 for 10 cycles after first draw_valid -> draw_valid and payload stable for all 10 cycles; accepted on cycle 11.
REQ-036 18 consecutive diff=1 cells with draw_ready=0 -> count saturates at 16 while the head entry is held in output registers, overflow=1, and the retained entries are emitted in order afterwards.
REQ-037 Full FIFO plus push and pop in the same cycle -> count stays 16, overflow stays 0.
REQ-038 nrst=0 during WAIT_DONE with count=5 -> next cycle count=0, draw_valid=0, idle=1, and a later draw_done pulse produces no request.
